register_file_16: RTL and testbench

REGISTER_FILE_16 -- requirements
Module: register_file_16

---
 rtl/register_file_16_pkg.sv | 25 ++
 rtl/register_file_16_decoder.sv | 25 ++
 rtl/register_file_16.sv | 170 +++++++++++++++++
 tb/tb_register_file_16.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_16_pkg.sv
// -----------------------------------------------------------------------------
// register_file_16_pkg
//
// Shared definitions for the 16-entry register file:
//   REGFILE_ENTRIES  - number of entries (fixed at 16)
//   REGFILE_ADDR_W   - width of an entry index
//   regfile_state_t  - clear-sweep FSM state (IDLE, CLEAR)
//   is_last_entry()  - true when an index addresses the final entry
// -----------------------------------------------------------------------------
package register_file_16_pkg;

    localparam int REGFILE_ENTRIES = 16;
    localparam int REGFILE_ADDR_W  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } regfile_state_t;

    // The sweep finishes on the cycle that clears the highest-numbered entry.
    function automatic logic is_last_entry(input logic [REGFILE_ADDR_W-1:0] idx);
        return idx == REGFILE_ADDR_W'(REGFILE_ENTRIES - 1);
    endfunction

endpackage

// File: rtl/register_file_16_decoder.sv
// -----------------------------------------------------------------------------
// decoder_4_to_16
//
// Converts a 4-bit index into a one-hot 16-bit enable vector. When ena is low
// the output is all zeros.
//
// Ports:
//   ena  in   1   global enable
//   in   in   4   index to decode
//   out  out  16  one-hot enables (bit[in] set when ena)
// -----------------------------------------------------------------------------
module decoder_4_to_16 (
    input  logic        ena,
    input  logic [3:0]  in,
    output logic [15:0] out
);

    always_comb begin
        out = '0;
        if (ena) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/register_file_16.sv
// -----------------------------------------------------------------------------
// register_file_16
//
// 16-entry register file with one write port, two combinational read ports
// and a background clear sweep that zeroes one entry per cycle.
//
// Handshake: a write is accepted on a rising edge where wr_ena && wr_ready.
// wr_ready is low for the whole sweep; a write offered then is dropped, not
// queued, so the requester must hold or retry it.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   defined   - a read of the entry being written this cycle returns wr_data
//   undefined - that read returns the stored (pre-write) value
//
// Parameters:
//   WIDTH       data width of each entry
//   DEPTH_LOG2  index width; only 4 (16 entries) is supported
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   wr_ena     in   1      write request
//   wr_addr    in   4      write index
//   wr_data    in   WIDTH  write data
//   wr_ready   out  1      write accepted this cycle when high
//   rd_addr0   in   4      read index, port 0
//   rd_addr1   in   4      read index, port 1
//   rd_data0   out  WIDTH  read data, port 0 (combinational)
//   rd_data1   out  WIDTH  read data, port 1 (combinational)
//   clr_req    in   1      start a clear sweep (ignored while sweeping)
//   clr_busy   out  1      clear sweep in progress
//   clr_done   out  1      one-cycle pulse as the sweep returns to IDLE
//   dbg_state  out  1      current FSM state for observation
// -----------------------------------------------------------------------------
module register_file_16
    import register_file_16_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_ena,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  wr_ready,
    input  logic [DEPTH_LOG2-1:0] rd_addr0,
    input  logic [DEPTH_LOG2-1:0] rd_addr1,
    output logic [WIDTH-1:0]      rd_data0,
    output logic [WIDTH-1:0]      rd_data1,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done,
    output regfile_state_t        dbg_state
);

    // -------------------------------------------------------------------------
    // Storage and control state
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]          mem [REGFILE_ENTRIES];
    regfile_state_t            state_q;
    regfile_state_t            state_d;
    logic [REGFILE_ADDR_W-1:0] cnt_q;
    logic                      done_q;
    logic                      sweeping;
    logic                      wr_fire;
    logic [REGFILE_ENTRIES-1:0] wr_onehot;

    assign sweeping = (state_q == CLEAR);
    assign wr_fire  = wr_ena & wr_ready;

    // -------------------------------------------------------------------------
    // Write-enable decode
    // -------------------------------------------------------------------------
    decoder_4_to_16 u_wr_decode (
        .ena (wr_fire),
        .in  (wr_addr),
        .out (wr_onehot)
    );

    // -------------------------------------------------------------------------
    // FSM: state register (also owns sweep counter and done pulse)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // Counter runs only while sweeping; the 15 -> 0 wrap leaves it
            // at 0 ready for the next sweep.
            cnt_q   <= sweeping ? cnt_q + 1'b1 : '0;
            // Pulse in the cycle after entry 15 is cleared, i.e. the first
            // cycle back in IDLE.
            done_q  <= sweeping && is_last_entry(cnt_q);
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                // clr_req is deliberately not looked at here: a request
                // during a sweep neither restarts nor extends it.
                if (is_last_entry(cnt_q)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        clr_busy  = sweeping;
        wr_ready  = ~sweeping;
        clr_done  = done_q;
        dbg_state = state_q;
    end

    // -------------------------------------------------------------------------
    // Entry storage. Writes and sweep clears never coincide because wr_ready
    // is low for the whole sweep. A write accepted on the same edge as
    // clr_req lands first and is then zeroed when the sweep reaches it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGFILE_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REGFILE_ENTRIES; i++) begin
                if (sweeping && (cnt_q == REGFILE_ADDR_W'(i))) begin
                    mem[i] <= '0;
                end else if (wr_onehot[i]) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Combinational read ports
    // -------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rd_data0 = (wr_fire && (wr_addr == rd_addr0)) ? wr_data : mem[rd_addr0];
        rd_data1 = (wr_fire && (wr_addr == rd_addr1)) ? wr_data : mem[rd_addr1];
    end
`else
    always_comb begin
        rd_data0 = mem[rd_addr0];
        rd_data1 = mem[rd_addr1];
    end
`endif

endmodule

// File: tb/tb_register_file_16.sv
// -----------------------------------------------------------------------------
// tb_register_file_16
//
// Directed bench for register_file_16. Inputs change 1 ns after the rising
// edge; outputs are sampled 2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_register_file_16;
    import register_file_16_pkg::*;

    localparam int WIDTH = 32;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic             clk;
    logic             rst;
    logic             wr_ena;
    logic [3:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic [3:0]       rd_addr0;
    logic [3:0]       rd_addr1;
    logic [WIDTH-1:0] rd_data0;
    logic [WIDTH-1:0] rd_data1;
    logic             clr_req;
    logic             clr_busy;
    logic             clr_done;
    regfile_state_t   dbg_state;

    int tests;
    int fails;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    register_file_16 #(.WIDTH(WIDTH), .DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_ena    (wr_ena),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_addr0  (rd_addr0),
        .rd_addr1  (rd_addr1),
        .rd_data0  (rd_data0),
        .rd_data1  (rd_data1),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .dbg_state (dbg_state)
    );

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [WIDTH-1:0] d);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_ena  = 1'b0;
    endtask

    // OR of every entry, read one per cycle through port 0.
    task automatic or_all_entries(output logic [WIDTH-1:0] acc);
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            rd_addr0 = 4'(i);
            #1;
            acc = acc | rd_data0;
            step();
        end
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] exp_same;
        int busy_n;
        int done_n;
        int done_at;

        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        wr_ena   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr0 = '0;
        rd_addr1 = '0;
        clr_req  = 1'b0;

        // ---- reset ----------------------------------------------------------
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_busy",  32'(clr_busy),  32'd0);
        check("reset_done",  32'(clr_done),  32'd0);
        check("reset_ready", 32'(wr_ready),  32'd1);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        check("reset_rd0",   rd_data0,       32'd0);
        step();

        // ---- basic write / read ---------------------------------------------
        write_entry(4'd5, 32'hDEADBEEF);
        rd_addr0 = 4'd5;
        rd_addr1 = 4'd4;
        #1;
        check("wr5_rd0", rd_data0, 32'hDEADBEEF);
        check("rd4_rd1", rd_data1, 32'h0);
        rd_addr1 = 4'd5;
        #1;
        check("same_addr_rd1", rd_data1, 32'hDEADBEEF);
        step();

        // ---- fill, then full sweep with mid-sweep probes --------------------
        for (int i = 0; i < 16; i++) begin
            write_entry(4'(i), 32'(i) + 32'h100);
        end
        rd_addr0 = 4'd15;
        rd_addr1 = 4'd5;
        #1;
        check("fill_e15", rd_data0, 32'h10F);
        check("fill_e5",  rd_data1, 32'h105);

        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("sweep_c1_busy",  32'(clr_busy),  32'd1);
        check("sweep_c1_ready", 32'(wr_ready),  32'd0);
        check("sweep_c1_state", 32'(dbg_state), 32'(CLEAR));
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        for (int k = 1; k <= 24; k++) begin
            if (clr_busy) busy_n++;
            if (clr_done) begin
                done_n++;
                done_at = k;
            end
            if (k == 8) begin
                rd_addr0 = 4'd3;
                rd_addr1 = 4'd12;
                #1;
                check("mid_e3",  rd_data0, 32'h0);
                check("mid_e12", rd_data1, 32'h10C);
                rd_addr0 = 4'd7;
                #1;
                check("mid_e7_unswept", rd_data0, 32'h107);
                wr_ena  = 1'b1;
                wr_addr = 4'd12;
                wr_data = 32'hFFFF_0012;
                #1;
                check("mid_wr_ready", 32'(wr_ready), 32'd0);
            end
            if (k == 9) wr_ena = 1'b0;
            if (k == 17) begin
                check("c17_ready", 32'(wr_ready), 32'd1);
            end
            step();
        end
        check("sweep_busy_cycles", 32'(busy_n),  32'd16);
        check("sweep_done_count",  32'(done_n),  32'd1);
        check("sweep_done_cycle",  32'(done_at), 32'd17);
        rd_addr1 = 4'd12;
        #1;
        check("dropped_wr_e12", rd_data1, 32'h0);
        or_all_entries(acc);
        check("sweep_all_zero", acc, 32'h0);

        // ---- same-cycle write and read --------------------------------------
        write_entry(4'd7, 32'h77);
        wr_ena   = 1'b1;
        wr_addr  = 4'd7;
        wr_data  = 32'h55;
        rd_addr0 = 4'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h55;
`else
        exp_same = 32'h77;
`endif
        check("same_cycle_rd", rd_data0, exp_same);
        step();
        wr_ena = 1'b0;
        #1;
        check("next_cycle_rd", rd_data0, 32'h55);

        // ---- clr_req with write, second clr_req mid-sweep -------------------
        wr_ena  = 1'b1;
        wr_addr = 4'd2;
        wr_data = 32'h222;
        clr_req = 1'b1;
        step();
        wr_ena   = 1'b0;
        clr_req  = 1'b0;
        rd_addr0 = 4'd2;
        #1;
        check("wr_with_req_committed", rd_data0, 32'h222);
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        for (int k = 1; k <= 24; k++) begin
            if (clr_busy) busy_n++;
            if (clr_done) begin
                done_n++;
                done_at = k;
            end
            clr_req = (k == 5);
            step();
        end
        clr_req = 1'b0;
        check("req2_busy_cycles", 32'(busy_n),  32'd16);
        check("req2_done_count",  32'(done_n),  32'd1);
        check("req2_done_cycle",  32'(done_at), 32'd17);
        rd_addr0 = 4'd2;
        #1;
        check("req2_e2_zero", rd_data0, 32'h0);

        // ---- reset mid-sweep ------------------------------------------------
        for (int i = 0; i < 16; i++) begin
            write_entry(4'(i), 32'(i) + 32'h100);
        end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 1; k < 10; k++) begin
            step();
        end
        rd_addr0 = 4'd9;
        #1;
        check("pre_rst_e9", rd_data0, 32'h109);
        // Reset alongside a write and a clear request: reset wins.
        rst     = 1'b1;
        wr_ena  = 1'b1;
        wr_addr = 4'd14;
        wr_data = 32'hABCD;
        clr_req = 1'b1;
        step();
        rst     = 1'b0;
        wr_ena  = 1'b0;
        clr_req = 1'b0;
        check("rst_mid_busy",  32'(clr_busy), 32'd0);
        check("rst_mid_done",  32'(clr_done), 32'd0);
        check("rst_mid_ready", 32'(wr_ready), 32'd1);
        done_n = 0;
        busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (clr_done) done_n++;
            if (clr_busy) busy_n++;
            step();
        end
        check("rst_no_done", 32'(done_n), 32'd0);
        check("rst_no_busy", 32'(busy_n), 32'd0);
        or_all_entries(acc);
        check("rst_all_zero", acc, 32'h0);

        // ---- report ---------------------------------------------------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
